bb_bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares the Blackbone bus between MASTERS requesters.

---
 rtl/bb_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_bb_bus_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bb_bus_arbiter.sv
// Round-robin Blackbone bus arbiter with registered one-hot grant and bus_hold parking.
// Optional tenure limit enabled by defining BB_ARB_BURST_LIMIT_EN.
module bb_bus_arbiter #(
    parameter  int unsigned MASTERS   = 2,
    parameter  int unsigned MAX_BURST = 16,
    localparam int unsigned IDX_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [MASTERS-1:0] req_i,
    output logic [MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_vld_o,
    input  logic               bus_hold_i,
    output logic               bus_hold_ack_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [MASTERS-1:0] owner_oh;
    logic [MASTERS-1:0] others;
    logic [MASTERS-1:0] grant_d;
    logic               grant_vld_d;
    logic               hold_ack_d;
    logic               new_grant;
    logic               revoke;

    assign owner_oh    = MASTERS'(1) << owner_q;
    assign others      = req_i & ~owner_oh;
    assign grant_idx_o = owner_q;

    // First requester after 'last', wrapping; only meaningful when req is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        int unsigned      idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MASTERS; i++) begin
            idx = 32'(last) + i;
            if (idx >= MASTERS) idx = idx - MASTERS;
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef BB_ARB_BURST_LIMIT_EN
    localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] tenure_q;

    // Tenure counter: restarts at 1 on every new grant, saturates at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tenure_q <= '0;
        end else if (new_grant) begin
            tenure_q <= CNT_W'(1);
        end else if (state_q == GRANT && tenure_q != CNT_MAX) begin
            tenure_q <= tenure_q + CNT_W'(1);
        end
    end

    assign revoke = (state_q == GRANT) && (tenure_q == CNT_MAX) && ((|others) || bus_hold_i);
`else
    logic unused_max_burst;
    assign unused_max_burst = (MAX_BURST == 0);
    assign revoke           = 1'b0;
`endif

    // Next state: hold parks the bus, release hands over on the same edge.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_hold_i) begin
                    state_d = HOLD;
                end else if (|req_i) begin
                    state_d   = GRANT;
                    owner_d   = rr_pick(req_i, last_q);
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!req_i[owner_q] || revoke) begin
                    last_d = owner_q;
                    if (bus_hold_i) begin
                        state_d = HOLD;
                    end else if (|others) begin
                        owner_d   = rr_pick(others, owner_q);
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!bus_hold_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the cycle after the edge, derived from the next state.
    always_comb begin
        grant_d     = '0;
        grant_vld_d = 1'b0;
        hold_ack_d  = 1'b0;
        if (state_d == GRANT) begin
            grant_d     = MASTERS'(1) << owner_d;
            grant_vld_d = 1'b1;
        end
        if (state_d == HOLD) hold_ack_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            last_q         <= IDX_W'(MASTERS - 1);
            grant_o        <= '0;
            grant_vld_o    <= 1'b0;
            bus_hold_ack_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            grant_o        <= grant_d;
            grant_vld_o    <= grant_vld_d;
            bus_hold_ack_o <= hold_ack_d;
        end
    end

endmodule

// File: tb/tb_bb_bus_arbiter.sv
// Directed-vector bench for bb_bus_arbiter (4 masters, burst limit 4 when the macro is on).
module tb_bb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       hold = 1'b0;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       vld;
    logic       ack;

    int vectors = 0;
    int miscompares = 0;

    bb_bus_arbiter #(.MASTERS(4), .MAX_BURST(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .grant_o       (grant),
        .grant_idx_o   (idx),
        .grant_vld_o   (vld),
        .bus_hold_i    (hold),
        .bus_hold_ack_o(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       hold;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       ack;
    } vec_t;

    vec_t tbl[39];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req   = '0;
        hold  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei,
                         input logic ea);
        logic ev;
        ev = |eg;
        vectors++;
        if (grant !== eg || vld !== ev || ack !== ea || (ev && idx !== ei)) begin
            miscompares++;
            $display("FAIL %s: got grant=%b idx=%0d vld=%b ack=%b, want grant=%b idx=%0d vld=%b ack=%b",
                     name, grant, idx, vld, ack, eg, ei, ev, ea);
        end
    endtask

    task automatic check_inv(input string name);
        vectors++;
        if (!$onehot0(grant) || vld !== (|grant) || (ack && vld)) begin
            miscompares++;
            $display("FAIL %s: invariant broken grant=%b vld=%b ack=%b", name, grant, vld, ack);
        end
    endtask

    initial begin
        // round robin 0,1,2,3,0 with 3-cycle tenures and one-cycle drops
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[3]  = '{4'b1110, 1'b0, 4'b0010, 2'd1, 1'b0};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0};
        tbl[6]  = '{4'b1101, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[9]  = '{4'b1011, 1'b0, 4'b1000, 2'd3, 1'b0};
        tbl[10] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0};
        tbl[11] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0};
        tbl[12] = '{4'b0111, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[13] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        // hold and request together from IDLE
        tbl[14] = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[15] = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[16] = '{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[17] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[18] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        // hold raised during tenure of master 1
        tbl[19] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0};
        tbl[20] = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b0};
        tbl[21] = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b0};
        tbl[22] = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[23] = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[24] = '{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[25] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0};
        // hold pulse withdrawn before release has no effect
        tbl[26] = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0};
        tbl[27] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[28] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[29] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[30] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        // single requester through IDLE, then non-owner requests
        tbl[31] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[32] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[33] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[34] = '{4'b1100, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[35] = '{4'b1101, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[36] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0};
        tbl[37] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[38] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};

        reset_dut();
        check("reset_state", 4'b0000, 2'd0, 1'b0);

        // async reset in the middle of a grant
        req = 4'b0011;
        step();
        check("pre_reset_grant", 4'b0001, 2'd0, 1'b0);
        step();
        check("pre_reset_hold", 4'b0001, 2'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (grant !== 4'b0000 || idx !== 2'd0 || vld !== 1'b0 || ack !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got grant=%b idx=%0d vld=%b ack=%b, want all zero",
                     grant, idx, vld, ack);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("post_reset_grant", 4'b0001, 2'd0, 1'b0);

        reset_dut();
        for (int i = 0; i < 39; i++) begin
            req  = tbl[i].req;
            hold = tbl[i].hold;
            step();
            check($sformatf("vec%0d", i), tbl[i].grant, tbl[i].idx, tbl[i].ack);
            check_inv($sformatf("vec%0d_inv", i));
        end

        // constant contention: alternation only when the tenure limit is built in
        reset_dut();
        req = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            logic [3:0] eg;
            logic [1:0] ei;
`ifdef BB_ARB_BURST_LIMIT_EN
            eg = (((k / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
            ei = (((k / 4) % 2) == 0) ? 2'd0 : 2'd1;
`else
            eg = 4'b0001;
            ei = 2'd0;
`endif
            step();
            check($sformatf("burst%0d", k), eg, ei, 1'b0);
        end
        req = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("solo%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        req = 4'b0000;
        step();
        check("solo_release", 4'b0000, 2'd0, 1'b0);

        // random traffic against the structural invariants
        for (int k = 0; k < 400; k++) begin
            req  = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 7) == 0);
            step();
            check_inv($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
